// File: rtl/xbar_scheduler_if.sv
// Crossbar scheduler bus: header requests and routes from the input buffers,
// grants and mux select tables back to the buffers and crossbar.
interface xbar_scheduler_if #(
    parameter int NPORT = 5,
    parameter int PSEL  = 3
);
    logic [NPORT-1:0]       h;
    logic [NPORT*NPORT-1:0] route;
    logic [NPORT-1:0]       sender;
    logic [NPORT-1:0]       ack_h;
    logic [NPORT-1:0]       free;
    logic [NPORT*PSEL-1:0]  mux_in;
    logic [NPORT*PSEL-1:0]  mux_out;
    logic                   busy;

    modport master (
        output h, route, sender,
        input  ack_h, free, mux_in, mux_out, busy
    );

    modport slave (
        input  h, route, sender,
        output ack_h, free, mux_in, mux_out, busy
    );
endinterface

// File: rtl/xbar_scheduler.sv
// Router crossbar scheduler: round-robin arbitration of header requests,
// route validation, output ownership tracking and mux select programming.
module xbar_scheduler #(
    parameter int NPORT = 5,
    parameter int PSEL  = 3
) (
    input logic             clk,
    input logic             reset,
    xbar_scheduler_if.slave bus
);
    localparam logic [PSEL-1:0]  LOCAL = PSEL'(NPORT - 1);
    localparam logic [NPORT-1:0] ONE   = {{(NPORT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_CHECK, S_GRANT} state_t;

    state_t           state;
    state_t           state_next;
    logic [PSEL-1:0]  sel;
    logic [PSEL-1:0]  ptr;
    logic [PSEL-1:0]  out_idx;
    logic [NPORT-1:0] ack_h;
    logic [NPORT-1:0] free;
    logic [NPORT-1:0] conn_valid;
    logic [NPORT-1:0] sender_prev;
    logic [PSEL-1:0]  mux_in_tbl  [NPORT];
    logic [PSEL-1:0]  mux_out_tbl [NPORT];

    logic [NPORT-1:0] req;
    logic             arb_found;
    logic [PSEL-1:0]  arb_idx;
    logic [NPORT-1:0] r;
    logic             r_valid;
    logic [PSEL-1:0]  r_idx;
    logic             load_sel;
    logic             latch_out;
    logic             pass_turn;
    logic             do_grant;

    // An input that was just acked is masked so it is not re-arbitrated while it drops h.
    assign req = bus.h & ~ack_h;

    // Round-robin search starting one past the pointer; the nearest requester wins.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = NPORT; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NPORT;
            if (req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = PSEL'(idx);
            end
        end
    end

    // Decode the selected input's route: must be one-hot and not a U-turn (LOCAL may loop back).
    always_comb begin
        r     = bus.route[int'(sel)*NPORT +: NPORT];
        r_idx = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (r[o]) begin
                r_idx = PSEL'(o);
            end
        end
        r_valid = (r != '0) && ((r & (r - ONE)) == '0)
                  && !((r == (ONE << sel)) && (sel != LOCAL));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        load_sel   = 1'b0;
        latch_out  = 1'b0;
        pass_turn  = 1'b0;
        do_grant   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_next = S_ARB;
                end
            end
            S_ARB: begin
                if (arb_found) begin
                    load_sel   = 1'b1;
                    state_next = S_CHECK;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (r_valid && ((r & free) != '0)) begin
                    latch_out  = 1'b1;
                    state_next = S_GRANT;
                end else begin
                    pass_turn  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_GRANT: begin
                do_grant   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pointer, grant bookkeeping and releases; a grant is applied after releases so it wins on the same input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel         <= '0;
            ptr         <= LOCAL;
            out_idx     <= '0;
            ack_h       <= '0;
            free        <= '1;
            conn_valid  <= '0;
            sender_prev <= '0;
            for (int i = 0; i < NPORT; i++) begin
                mux_in_tbl[i]  <= '0;
                mux_out_tbl[i] <= '0;
            end
        end else begin
            sender_prev <= bus.sender;
            ack_h       <= '0;
            if (load_sel) begin
                sel <= arb_idx;
            end
            if (latch_out) begin
                out_idx <= r_idx;
            end
            if (pass_turn) begin
                ptr <= sel;
            end
            for (int i = 0; i < NPORT; i++) begin
                if (sender_prev[i] && !bus.sender[i] && conn_valid[i]) begin
                    free[mux_in_tbl[i]] <= 1'b1;
                    conn_valid[i]       <= 1'b0;
                end
            end
            if (do_grant) begin
                mux_in_tbl[sel]      <= out_idx;
                mux_out_tbl[out_idx] <= sel;
                free[out_idx]        <= 1'b0;
                conn_valid[sel]      <= 1'b1;
                ack_h[sel]           <= 1'b1;
                ptr                  <= sel;
            end
        end
    end

    assign bus.ack_h = ack_h;
    assign bus.free  = free;
    assign bus.busy  = (state != S_IDLE);

    for (genvar g = 0; g < NPORT; g++) begin : g_flat
        assign bus.mux_in[g*PSEL +: PSEL]  = mux_in_tbl[g];
        assign bus.mux_out[g*PSEL +: PSEL] = mux_out_tbl[g];
    end
endmodule

// File: tb/tb_xbar_scheduler.sv
// Self-checking bench for xbar_scheduler: expected grants are queued when
// requests are driven and popped when ack_h pulses.
module tb_xbar_scheduler;
    localparam int NPORT = 5;
    localparam int PSEL  = 3;

    typedef struct {
        int src;
        int dst;
    } grant_t;

    logic             clk = 1'b0;
    logic             reset;
    int               ntests = 0;
    int               nfail  = 0;
    grant_t           sb[$];
    logic [NPORT-1:0] exp_free;

    xbar_scheduler_if #(.NPORT(NPORT), .PSEL(PSEL)) bus ();

    xbar_scheduler #(.NPORT(NPORT), .PSEL(PSEL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case something never terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [NPORT-1:0] onehot(input int p);
        logic [NPORT-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [PSEL-1:0] mux_in_of(input int i);
        return bus.mux_in[i*PSEL +: PSEL];
    endfunction

    function automatic logic [PSEL-1:0] mux_out_of(input int o);
        return bus.mux_out[o*PSEL +: PSEL];
    endfunction

    task automatic do_reset();
        bus.h      = '0;
        bus.route  = '0;
        bus.sender = '0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        sb.delete();
        exp_free   = '1;
    endtask

    // Requester model: wait for an ack pulse (bounded), then drop the acked header.
    task automatic await_ack(input int budget, output logic [NPORT-1:0] mask, output int cycles);
        mask   = '0;
        cycles = 0;
        while (cycles < budget && mask == '0) begin
            @(negedge clk);
            cycles++;
            mask = bus.ack_h;
        end
        bus.h = bus.h & ~mask;
    endtask

    task automatic test_reset();
        do_reset();
        ntests++;
        if ({bus.ack_h, bus.busy} !== {{NPORT{1'b0}}, 1'b0}) begin
            nfail++;
            $display("[TB] FAIL reset_ctrl: ack_h=%b busy=%b required ack_h=0 busy=0", bus.ack_h, bus.busy);
        end
        ntests++;
        if ({bus.free, bus.mux_in, bus.mux_out} !== {{NPORT{1'b1}}, {(2*NPORT*PSEL){1'b0}}}) begin
            nfail++;
            $display("[TB] FAIL reset_tables: free=%b mux_in=%h mux_out=%h required free=11111 mux=0",
                     bus.free, bus.mux_in, bus.mux_out);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [NPORT-1:0] mask;
        int               cyc;
        do_reset();
        bus.h = 5'b00010;
        bus.route[1*NPORT +: NPORT] = onehot(3);
        await_ack(20, mask, cyc);
        ntests++;
        if (bus.free !== 5'b10111) begin
            nfail++;
            $display("[TB] FAIL midgrant_pre_free: got %b want 10111", bus.free);
        end
        @(negedge clk);
        bus.h = 5'b00001;
        bus.route[0*NPORT +: NPORT] = onehot(2);
        repeat (3) @(posedge clk);
        #1;
        ntests++;
        if (bus.busy !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL midgrant_busy: got %b want 1", bus.busy);
        end
        reset = 1'b1;
        #1;
        ntests++;
        if ({bus.ack_h, bus.free, bus.busy} !== {5'b00000, 5'b11111, 1'b0}) begin
            nfail++;
            $display("[TB] FAIL midgrant_reset_ctrl: ack_h=%b free=%b busy=%b want 00000 11111 0",
                     bus.ack_h, bus.free, bus.busy);
        end
        ntests++;
        if ({bus.mux_in, bus.mux_out} !== '0) begin
            nfail++;
            $display("[TB] FAIL midgrant_reset_mux: mux_in=%h mux_out=%h want 0", bus.mux_in, bus.mux_out);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_grant();
        grant_t           e;
        logic [NPORT-1:0] mask;
        int               cyc;
        do_reset();
        bus.h = 5'b00001;
        bus.route[0*NPORT +: NPORT] = 5'b00100;
        sb.push_back('{src: 0, dst: 2});
        e = sb.pop_front();
        await_ack(20, mask, cyc);
        exp_free[e.dst] = 1'b0;
        ntests++;
        if (mask !== onehot(e.src) || cyc !== 4) begin
            nfail++;
            $display("[TB] FAIL single_ack: ack_h=%b cycle=%0d want %b cycle=4", mask, cyc, onehot(e.src));
        end
        ntests++;
        if ({mux_in_of(e.src), mux_out_of(e.dst), bus.free} !== {PSEL'(e.dst), PSEL'(e.src), exp_free}) begin
            nfail++;
            $display("[TB] FAIL single_tables: mux_in=%0d mux_out=%0d free=%b want %0d %0d %b",
                     mux_in_of(e.src), mux_out_of(e.dst), bus.free, e.dst, e.src, exp_free);
        end
        @(negedge clk);
        ntests++;
        if (bus.ack_h !== '0) begin
            nfail++;
            $display("[TB] FAIL single_pulse: ack_h=%b want 00000", bus.ack_h);
        end
    endtask

    task automatic test_two_inputs();
        grant_t           e;
        logic [NPORT-1:0] mask;
        int               cyc;
        do_reset();
        bus.route[0*NPORT +: NPORT] = onehot(4);
        bus.route[1*NPORT +: NPORT] = onehot(2);
        bus.h = 5'b00011;
        sb.push_back('{src: 0, dst: 4});
        sb.push_back('{src: 1, dst: 2});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            await_ack(30, mask, cyc);
            exp_free[e.dst] = 1'b0;
            ntests++;
            if (mask !== onehot(e.src)) begin
                nfail++;
                $display("[TB] FAIL two_ack: got %b want %b", mask, onehot(e.src));
            end
            ntests++;
            if ({mux_in_of(e.src), mux_out_of(e.dst), bus.free} !== {PSEL'(e.dst), PSEL'(e.src), exp_free}) begin
                nfail++;
                $display("[TB] FAIL two_tables: mux_in=%0d mux_out=%0d free=%b want %0d %0d %b",
                         mux_in_of(e.src), mux_out_of(e.dst), bus.free, e.dst, e.src, exp_free);
            end
            @(negedge clk);
            ntests++;
            if (bus.ack_h !== '0) begin
                nfail++;
                $display("[TB] FAIL two_pulse: ack_h=%b want 00000", bus.ack_h);
            end
        end
        ntests++;
        if (bus.free !== 5'b01011) begin
            nfail++;
            $display("[TB] FAIL two_final_free: got %b want 01011", bus.free);
        end
    endtask

    task automatic test_release_retry();
        grant_t           e;
        logic [NPORT-1:0] mask;
        int               cyc;
        int               stray;
        do_reset();
        bus.route[0*NPORT +: NPORT] = onehot(2);
        bus.route[3*NPORT +: NPORT] = onehot(2);
        bus.h = 5'b00001;
        sb.push_back('{src: 0, dst: 2});
        sb.push_back('{src: 3, dst: 2});
        for (int n = 0; n < 2; n++) begin
            e = sb.pop_front();
            if (n == 1) begin
                bus.sender[0] = 1'b1;
                bus.h[3] = 1'b1;
                stray = 0;
                repeat (15) begin
                    @(negedge clk);
                    if (bus.ack_h != '0) stray++;
                end
                ntests++;
                if (stray !== 0) begin
                    nfail++;
                    $display("[TB] FAIL blocked_no_ack: %0d ack pulses seen, want 0", stray);
                end
                bus.sender[0] = 1'b0;
                @(negedge clk);
                exp_free[2] = 1'b1;
                ntests++;
                if (bus.free !== exp_free) begin
                    nfail++;
                    $display("[TB] FAIL release_free: got %b want %b", bus.free, exp_free);
                end
            end
            await_ack(30, mask, cyc);
            exp_free[e.dst] = 1'b0;
            ntests++;
            if (mask !== onehot(e.src)) begin
                nfail++;
                $display("[TB] FAIL retry_ack: got %b want %b", mask, onehot(e.src));
            end
            ntests++;
            if ({mux_in_of(e.src), mux_out_of(e.dst), bus.free} !== {PSEL'(e.dst), PSEL'(e.src), exp_free}) begin
                nfail++;
                $display("[TB] FAIL retry_tables: mux_in=%0d mux_out=%0d free=%b want %0d %0d %b",
                         mux_in_of(e.src), mux_out_of(e.dst), bus.free, e.dst, e.src, exp_free);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_route();
        grant_t           e;
        logic [NPORT-1:0] mask;
        logic [NPORT-1:0] bad [2];
        int               cyc;
        int               stray;
        bad[0] = 5'b00110;
        bad[1] = 5'b00010;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            bus.route[1*NPORT +: NPORT] = bad[v];
            bus.route[2*NPORT +: NPORT] = onehot(0);
            bus.route[4*NPORT +: NPORT] = onehot(4);
            bus.h = 5'b10110;
            sb.push_back('{src: 2, dst: 0});
            sb.push_back('{src: 4, dst: 4});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                await_ack(40, mask, cyc);
                exp_free[e.dst] = 1'b0;
                ntests++;
                if (mask !== onehot(e.src)) begin
                    nfail++;
                    $display("[TB] FAIL badroute_ack: route1=%b got %b want %b", bad[v], mask, onehot(e.src));
                end
                ntests++;
                if ({mux_in_of(e.src), mux_out_of(e.dst), bus.free} !== {PSEL'(e.dst), PSEL'(e.src), exp_free}) begin
                    nfail++;
                    $display("[TB] FAIL badroute_tables: mux_in=%0d mux_out=%0d free=%b want %0d %0d %b",
                             mux_in_of(e.src), mux_out_of(e.dst), bus.free, e.dst, e.src, exp_free);
                end
            end
            stray = 0;
            repeat (15) begin
                @(negedge clk);
                if (bus.ack_h != '0) stray++;
            end
            ntests++;
            if (stray !== 0 || bus.free !== 5'b01110) begin
                nfail++;
                $display("[TB] FAIL badroute_dropped: route1=%b stray acks=%0d free=%b want 0 01110",
                         bad[v], stray, bus.free);
            end
        end
    endtask

    task automatic test_back_to_back();
        grant_t           e;
        logic [NPORT-1:0] mask;
        int               cyc;
        int               order [5];
        do_reset();
        bus.route[2*NPORT +: NPORT] = onehot(0);
        bus.h = 5'b00100;
        await_ack(20, mask, cyc);
        bus.sender[2] = 1'b1;
        @(negedge clk);
        bus.sender[2] = 1'b0;
        @(negedge clk);
        ntests++;
        if (bus.free !== 5'b11111 || mask !== 5'b00100) begin
            nfail++;
            $display("[TB] FAIL b2b_setup: ack=%b free=%b want 00100 11111", mask, bus.free);
        end
        order = '{3, 4, 0, 1, 2};
        for (int i = 0; i < NPORT; i++) begin
            bus.route[i*NPORT +: NPORT] = onehot((i + 1) % NPORT);
        end
        for (int k = 0; k < NPORT; k++) begin
            sb.push_back('{src: order[k], dst: (order[k] + 1) % NPORT});
        end
        bus.h = 5'b11111;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            await_ack(30, mask, cyc);
            exp_free[e.dst] = 1'b0;
            ntests++;
            if (mask !== onehot(e.src)) begin
                nfail++;
                $display("[TB] FAIL b2b_order: got %b want %b", mask, onehot(e.src));
            end
            ntests++;
            if ({mux_in_of(e.src), mux_out_of(e.dst), bus.free} !== {PSEL'(e.dst), PSEL'(e.src), exp_free}) begin
                nfail++;
                $display("[TB] FAIL b2b_tables: mux_in=%0d mux_out=%0d free=%b want %0d %0d %b",
                         mux_in_of(e.src), mux_out_of(e.dst), bus.free, e.dst, e.src, exp_free);
            end
            @(negedge clk);
            ntests++;
            if (bus.ack_h !== '0) begin
                nfail++;
                $display("[TB] FAIL b2b_pulse: ack_h=%b want 00000", bus.ack_h);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        reset      = 1'b1;
        bus.h      = '0;
        bus.route  = '0;
        bus.sender = '0;
        exp_free   = '1;
        test_reset();
        test_reset_mid_grant();
        test_single_grant();
        test_two_inputs();
        test_release_retry();
        test_bad_route();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
